// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: zero-latency fetch in IDLE, and a
// valid/ready write port driven by a two-state load FSM that stalls the core.
module instr_mem_loadable #(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               stall,
  input  logic               load_start,
  input  logic               load_end,
  input  logic               wr_valid,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               wr_ready,
  output logic               load_done,
  output logic [ADDR_W:0]    words_loaded
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    ptr;
  logic [ADDR_W:0]      cnt;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic                 accept;
  logic                 last_word;
  logic                 finish;

  assign accept    = (state == LOAD) && wr_valid;
  assign last_word = accept && (ptr == LAST_ADDR);
  assign finish    = (state == LOAD) && (last_word || load_end);

  // Handshake outputs come straight from the state register.
  assign stall    = (state == LOAD);
  assign wr_ready = (state == LOAD);

  // Addresses beyond DEPTH (non-power-of-two sizes) and all loading cycles read as NOP.
  always_comb begin
    instr = '0;
    if ((state == IDLE) && ({1'b0, pc} < DEPTH_C))
      instr = mem[pc];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (accept) begin
      mem[ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      load_done    <= 1'b0;
      words_loaded <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            ptr   <= '0;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // The pointer parks on the last entry instead of wrapping.
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (!last_word)
              ptr <= ptr + 1'b1;
          end
          if (finish) begin
            state        <= IDLE;
            load_done    <= 1'b1;
            words_loaded <= cnt + {{ADDR_W{1'b0}}, accept};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, run-time-programmable instruction memory for the single-cycle processor. During normal execution it returns the instruction at `pc` combinationally, so it drops into the fetch path with zero latency. A load FSM with a valid/ready write port lets a host stream a new program into the array. While loading, the block holds the processor with `stall` and returns NOP.

## Interface
Parameters:
- `INSTR_W`, 12: instruction word width.
- `DEPTH`, 8: number of instruction words, 2..64; need not be a power of two.
- `ADDR_W`, `$clog2(DEPTH)`: width of `pc` and of the internal write pointer; derived, do not override.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_W  fetch address.
- `instr`  out  INSTR_W  instruction at `pc`.
- `stall`  out  1  high while a load is in progress; processor holds `pc`.
- `load_start`  in  1  begin a program load at address 0; sampled in IDLE only.
- `load_end`  in  1  terminate the load early; sampled in LOAD only.
- `wr_valid`  in  1  host has a word on `wr_data`.
- `wr_data`  in  INSTR_W  instruction word to write.
- `wr_ready`  out  1  block accepts a word this cycle.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `words_loaded`  out  ADDR_W+1  number of words written by the last completed load.

## Operation
- Storage: `DEPTH` x `INSTR_W` register array. The asynchronous reset clears every entry to 0 (NOP).
- FSM, two states:
  - IDLE (reset state):
    - `stall` = 0, `wr_ready` = 0.
    - `instr` = mem[`pc`] combinationally.
    - If `pc` >= `DEPTH`, `instr` = 0.
    - `wr_valid` is ignored.
    - `load_start` = 1 moves to LOAD, sets `ptr` = 0 and the internal word count = 0.
  - LOAD:
    - `stall` = 1, `wr_ready` = 1, `instr` = 0 regardless of `pc`.
    - `load_start` is ignored.
    - A word is accepted on a cycle where `wr_valid` & `wr_ready` = 1. On that edge: mem[`ptr`] <= `wr_data`, `ptr` += 1, count += 1.
    - Exit to IDLE when an accept occurs with `ptr` = DEPTH-1 (auto-finish; no wrap), or when `load_end` = 1.
    - If `load_end` and an accept occur in the same cycle, the word is written first, then the load finishes.
    - `load_end` with no accept finishes with the count unchanged. A zero-word load is legal: `words_loaded` = 0.
- Completion edge:
  - `words_loaded` <= final count.
  - `load_done` <= 1 for exactly one cycle, coincident with the first IDLE cycle.
- Entries not written by a partial load keep their previous contents.
- Width rules: `ptr` is ADDR_W bits. The count is ADDR_W+1 bits so that it can represent `DEPTH`. No arithmetic wraps.

## Timing
- Reset (any state, asynchronous):
  - State = IDLE, `ptr` = 0, count = 0, all memory entries = 0.
  - Outputs: `stall` = 0, `wr_ready` = 0, `load_done` = 0, `words_loaded` = 0, `instr` = 0.
- Reset mid-load aborts the load. No `load_done` is produced, and words already written are cleared.
- Read latency: 0 cycles. A word written at edge N is visible on `instr` from the first IDLE cycle onward.
- `load_start` at edge N gives `stall` = 1 and `wr_ready` = 1 during cycle N+1. The first write can occur at edge N+1.
- Back-to-back accepts sustain one word per cycle.
- `stall` and `wr_ready` are decoded from the state register only; they have no combinational path from any input.
- `instr` depends combinationally on `pc` and the state only.

## Test plan
- Reset: hold `reset_n` = 0, sweep `pc` 0..7 → `instr` = 0 for every `pc`; `stall` = 0, `wr_ready` = 0, `words_loaded` = 0.
- Full load, DEPTH = 8:
  - Stimulus: pulse `load_start`, then stream 12'h001..12'h008 back-to-back.
  - Auto-finish on the 8th accept. `load_done` pulses once, `words_loaded` = 8, `stall` drops.
  - `pc` = 3 → 12'h004; `pc` = 7 → 12'h008.
- Partial load with gaps:
  - Stimulus: `wr_valid` toggled 1,0,1,0,1, with `load_end` asserted on the 3rd accept (12'hA01, 12'hA02, 12'hA03).
  - `words_loaded` = 3; `pc` = 2 → 12'hA03; `pc` = 3 → its previous value 12'h004.
- Ignored inputs:
  - `wr_valid` = 1 with 12'hFFF in IDLE → no memory change.
  - `load_start` pulsed mid-LOAD → `ptr` not reset; the next word lands at the next address.
  - `pc` = 5 during LOAD → `instr` = 0.
- Reset mid-load: assert `reset_n` = 0 after 2 accepts → IDLE immediately, no `load_done`, `instr` = 0 at `pc` = 0 and `pc` = 1.
- Non-power-of-two, DEPTH = 6:
  - Load 6 words → auto-finish, `words_loaded` = 6.
  - `pc` = 6 and `pc` = 7 → `instr` = 0.
